way_decoder: RTL and testbench
==============================

WAY_DECODER -- requirements
Module: way_decoder

Interface
REQ-001 SHALL have parameter: ways, default 8, number of cache ways and width of the one-hot output.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  upstream presents a way index.
REQ-005 SHALL have port: in_ready  output  1  block accepts an index this cycle.
REQ-006 SHALL have port: in_way  input  $clog2(ways)  binary way index.
REQ-007 SHALL have port: out_valid  output  1  out_onehot holds a decoded mask.
REQ-008 SHALL have port: out_ready  input  1  downstream consumes the mask this cycle.
REQ-009 SHALL have port: out_onehot  output  ways  one-hot way-enable mask.
REQ-010 SHALL have port: err  output  1  sticky out-of-range flag; present in both builds.

Function
REQ-011 SHALL decode in_way = k to out_onehot with only bit k set, for 0 <= k < ways.
REQ-012 SHALL treat in_way >= ways (non-power-of-2 ways only) as out-of-range and decode it to an all-zero mask, with the handshake unchanged.
REQ-013 SHALL transfer an input when in_valid && in_ready on a rising edge, and an output when out_valid && out_ready on a rising edge.
REQ-014 SHALL register the output: an accepted index appears on out_onehot with out_valid=1 exactly 1 cycle after acceptance when the output stage is empty or draining.
REQ-015 SHALL hold two storage entries: an output register and a skid register.
REQ-016 SHALL drive in_ready directly from a flop, with in_ready = NOT skid_valid and no combinational path from out_ready.
REQ-017 SHALL define states EMPTY (no entries), ONE (output entry only) and FULL (output and skid entries).
REQ-018 SHALL make these transitions: EMPTY+accept -> ONE; ONE+accept with no drain -> FULL; ONE+drain with no accept -> EMPTY; ONE+accept and drain in the same cycle -> ONE (new mask loaded); FULL+drain -> ONE (skid entry moves to output, in_ready rises next cycle).
REQ-019 SHALL never accept in FULL, and SHALL lose or duplicate no entry under any in/out handshake combination.
REQ-020 SHALL hold out_onehot and out_valid stable while out_valid && !out_ready.
REQ-021 SHALL drive out_onehot to all-zero whenever out_valid=0.
REQ-022 SHALL allow ways=1: in_way is 1 bit wide, index 0 -> mask 1, index 1 -> out-of-range.

Reset
REQ-023 SHALL, on reset assertion and regardless of clk, immediately force state EMPTY, out_valid=0, out_onehot=0, in_ready=0 and err=0.
REQ-024 SHALL raise in_ready on the first rising edge after reset deassertion.
REQ-025 SHALL discard all entries when reset is asserted mid-transfer, with no output produced for them after release.

Configuration
REQ-026 SHALL compile out-of-range error tracking in or out with the macro WAY_DECODER_ERR_EN.
REQ-027 SHALL, with WAY_DECODER_ERR_EN defined, set err on the cycle after an out-of-range index is accepted and hold it at 1 until reset.
REQ-028 SHALL, with WAY_DECODER_ERR_EN undefined, tie err to 0 and keep the REQ-012 mask behaviour.

Verification
REQ-029 SHALL cover: ways=8, out_ready=1, in_way=5 with in_valid for 1 cycle -> next cycle out_valid=1, out_onehot=8'b0010_0000.
REQ-030 SHALL cover: ways=8, out_ready=0, indices 2 then 7 sent -> in_ready=0 after the second accept; out_onehot=8'h04 held; out_ready=1 gives 8'h04 then 8'h80; in_ready=1 again.
REQ-031 SHALL cover: ways=8, continuous in_valid and out_ready=1, indices 0..7 -> one mask per cycle 8'h01..8'h80 with no bubbles.
REQ-032 SHALL cover: ways=6 with WAY_DECODER_ERR_EN defined, in_way=6 -> out_onehot=6'b0 with out_valid=1, err=1 and sticky; without the macro err stays 0.
REQ-033 SHALL cover: FULL state, reset asserted mid-cycle -> out_valid=0, out_onehot=0, in_ready=0 immediately; in_ready=1 on the first edge after release; no stale mask emitted.

Source files
------------

// File: rtl/way_decoder.sv
// Binary way index -> one-hot way-enable mask, behind a two-entry (output + skid) valid/ready buffer.
// Define WAY_DECODER_ERR_EN to build the sticky out-of-range err flag; otherwise err is tied low.
module way_decoder #(
  parameter  int ways = 8,
  localparam int iw   = (ways > 1) ? $clog2(ways) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [iw-1:0]   in_way,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ways-1:0] out_onehot,
  output logic            err
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t          state;
  logic [ways-1:0] skid_onehot;
  logic [ways-1:0] dec;
  logic            accept;
  logic            drain;

  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

  // Indices >= ways match no bit, so out-of-range decodes to all-zero.
  always_comb begin
    dec = '0;
    for (int i = 0; i < ways; i++) dec[i] = (in_way == iw'(i));
  end

  // in_ready is a flop that tracks "skid register empty" for the next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= EMPTY;
      out_valid   <= 1'b0;
      out_onehot  <= '0;
      skid_onehot <= '0;
      in_ready    <= 1'b0;
    end else begin
      in_ready <= 1'b1;
      case (state)
        EMPTY: begin
          if (accept) begin
            out_onehot <= dec;
            out_valid  <= 1'b1;
            state      <= ONE;
          end
        end
        ONE: begin
          if (accept && !drain) begin
            skid_onehot <= dec;
            state       <= FULL;
            in_ready    <= 1'b0;
          end else if (accept && drain) begin
            out_onehot <= dec;
          end else if (drain) begin
            out_onehot <= '0;
            out_valid  <= 1'b0;
            state      <= EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            out_onehot <= skid_onehot;
            state      <= ONE;
          end else begin
            in_ready <= 1'b0;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef WAY_DECODER_ERR_EN
  logic oor;
  assign oor = (int'(in_way) >= ways);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)             err <= 1'b0;
    else if (accept && oor) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_way_decoder.sv
// Randomized + directed bench for way_decoder (ways = 8, 6, 1 side by side) against a queue model.
module tb_way_decoder;
  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, out_ready;
  logic [2:0] in_way;

  logic       rdy8, v8, err8;
  logic [7:0] oh8;
  logic       rdy6, v6, err6;
  logic [5:0] oh6;
  logic       rdy1, v1, err1;
  logic [0:0] oh1;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  way_decoder #(.ways(8)) u8 (.clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy8),
    .in_way(in_way), .out_valid(v8), .out_ready(out_ready), .out_onehot(oh8), .err(err8));
  way_decoder #(.ways(6)) u6 (.clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy6),
    .in_way(in_way), .out_valid(v6), .out_ready(out_ready), .out_onehot(oh6), .err(err6));
  way_decoder #(.ways(1)) u1 (.clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy1),
    .in_way(in_way[0:0]), .out_valid(v1), .out_ready(out_ready), .out_onehot(oh1), .err(err1));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] mask(input int idx, input int w);
    return (idx < w) ? 8'(1 << idx) : 8'h00;
  endfunction

`ifdef WAY_DECODER_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  // Model: FIFO of accepted indices, capacity two; head is what the output shows.
  int   q[$];
  logic m_rdy  = 1'b0;
  logic m_err6 = 1'b0;
  logic m_err1 = 1'b0;
  bit   m_acc, m_drn;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      m_rdy  = 1'b0;
      m_err6 = 1'b0;
      m_err1 = 1'b0;
    end else begin
      m_acc = in_valid && m_rdy;
      m_drn = (q.size() > 0) && out_ready;
      if (m_drn) void'(q.pop_front());
      if (m_acc) begin
        q.push_back(int'(in_way));
        if (ERR_ON && in_way >= 3'd6) m_err6 = 1'b1;
        if (ERR_ON && in_way[0])      m_err1 = 1'b1;
      end
      m_rdy = (q.size() < 2);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int  idx;
      logic ev;
      ev  = (q.size() > 0);
      idx = ev ? q[0] : 99;
      chk("rdy8", rdy8, m_rdy);
      chk("rdy6", rdy6, m_rdy);
      chk("rdy1", rdy1, m_rdy);
      chk("v8", v8, ev);
      chk("v6", v6, ev);
      chk("v1", v1, ev);
      chk("oh8", oh8, mask(idx, 8));
      chk("oh6", oh6, 32'(mask(idx, 6)));
      chk("oh1", oh1, 32'(mask(ev ? (idx & 1) : 99, 1) & 8'h01));
      chk("err8", err8, 1'b0);
      chk("err6", err6, m_err6);
      chk("err1", err1, m_err1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] one;
    one       = 8'h01;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_way    = '0;
    #1;
    chk("rst_rdy", rdy8, 1'b0);
    chk("rst_v", v8, 1'b0);
    chk("rst_oh", oh8, 8'h00);
    chk("rst_err", err6, 1'b0);
    chk_en = 1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("pre_edge_rdy", rdy8, 1'b0);
    step();
    chk("first_edge_rdy", rdy8, 1'b1);

    // Single index, immediate drain
    out_ready = 1'b1; in_valid = 1'b1; in_way = 3'd5;
    step();
    chk("k5_v", v8, 1'b1);
    chk("k5_oh", oh8, 8'b0010_0000);
    in_valid = 1'b0;
    step();
    chk("k5_gone", v8, 1'b0);

    // Fill to FULL under backpressure, then drain
    out_ready = 1'b0; in_valid = 1'b1; in_way = 3'd2;
    step();
    in_way = 3'd7;
    step();
    chk("full_rdy", rdy8, 1'b0);
    chk("full_oh", oh8, 8'h04);
    in_valid = 1'b0;
    step();
    chk("hold_oh", oh8, 8'h04);
    out_ready = 1'b1;
    step();
    chk("drain1_oh", oh8, 8'h80);
    chk("drain1_rdy", rdy8, 1'b1);
    step();
    chk("drain2_v", v8, 1'b0);

    // Back-to-back stream, no bubbles
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_way = 3'(i);
      step();
      chk("stream_oh", oh8, 32'(one << i));
      chk("stream_v", v8, 1'b1);
      if (i == 0) chk("w1_k0", oh1, 1'b1);
      if (i == 1) chk("w1_k1", oh1, 1'b0);
    end
    in_valid = 1'b0;
    step();

    // Out-of-range on ways=6
    in_valid = 1'b1; in_way = 3'd6;
    step();
    chk("oor_v", v6, 1'b1);
    chk("oor_oh", oh6, 6'b0);
    chk("oor_err", err6, ERR_ON);
    in_valid = 1'b0;
    step();
    step();
    chk("err_sticky", err6, ERR_ON);

    repeat (3000) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      in_way    = 3'($urandom_range(0, 7));
      step();
    end

    // Reset while FULL
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    out_ready = 1'b0; in_valid = 1'b1; in_way = 3'd3;
    step();
    in_way = 3'd4;
    step();
    chk("pre_rst_full", rdy8, 1'b0);
    in_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("arst_v", v8, 1'b0);
    chk("arst_oh", oh8, 8'h00);
    chk("arst_rdy", rdy8, 1'b0);
    chk("arst_err", err6, 1'b0);
    reset = 1'b0;
    out_ready = 1'b1;
    step();
    chk("rel_rdy", rdy8, 1'b1);
    chk("rel_nostale", v8, 1'b0);
    step();
    chk("rel_nostale2", v8, 1'b0);
    chk("rel_oh", oh8, 8'h00);

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
